// File: rtl/dp_pkg.sv
// dp_pkg: shared definitions for the multi-cycle control unit.
//   - state_e       : control FSM states
//   - inst_class_e  : instruction classes produced by the decoder
//   - opcode / funct3 / funct7 constants for the supported subset
//   - ALU_op codes, imm_sel codes and status flag bit indices
package dp_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WBK    = 3'd4,
        ST_BRANCH = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_BR  = 3'd4,
        CLS_ILL = 3'd5
    } inst_class_e;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1100;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Shared funct3 -> ALU function map used by both R-type and I-ALU.
    function automatic logic f3_is_alu(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_XOR) || (f3 == F3_OR) || (f3 == F3_AND);
    endfunction

    function automatic logic [3:0] f3_alu_op(input logic [2:0] f3);
        case (f3)
            F3_XOR:  return ALU_XOR;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/dp_decode.sv
// dp_decode: combinational instruction classifier.
//   inst    in  32  latched instruction word
//   cls     out     instruction class (CLS_ILL for unsupported encodings)
//   alu_op  out  4  ALU function for EXEC/WBK (XOR for branches)
//   imm_sel out  2  immediate format
//   legal   out  1  encoding is supported
module dp_decode
    import dp_pkg::*;
(
    input  logic [31:0] inst,
    output inst_class_e cls,
    output logic [3:0]  alu_op,
    output logic [1:0]  imm_sel,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_fields;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    // Register and immediate fields are routed by the datapath, not here.
    assign unused_fields = ^{inst[24:15], inst[11:7]};

    always_comb begin
        cls     = CLS_ILL;
        alu_op  = ALU_ADD;
        imm_sel = IMM_I;
        case (opcode)
            OP_R: begin
                if (f7 == F7_BASE && f3_is_alu(f3)) begin
                    cls    = CLS_R;
                    alu_op = f3_alu_op(f3);
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    cls    = CLS_R;
                    alu_op = ALU_SUB;
                end
            end
            OP_I: begin
                // funct7 is part of the immediate here, so it is not checked.
                if (f3_is_alu(f3)) begin
                    cls    = CLS_I;
                    alu_op = f3_alu_op(f3);
                end
            end
            OP_LW: begin
                if (f3 == F3_W) cls = CLS_LW;
            end
            OP_SW: begin
                if (f3 == F3_W) begin
                    cls     = CLS_SW;
                    imm_sel = IMM_S;
                end
            end
            OP_BR: begin
                if (f3 == F3_BEQ || f3 == F3_BNE) begin
                    cls     = CLS_BR;
                    alu_op  = ALU_XOR;
                    imm_sel = IMM_B;
                end
            end
            default: ;
        endcase
    end

    assign legal = (cls != CLS_ILL);

endmodule

// File: rtl/dp_control.sv
// dp_control: multi-cycle Moore control unit for the RV32 subset datapath.
// Ports:
//   clock, reset (sync, active-high)
//   inst_in[31:0]    instruction word, latched in FETCH
//   status_flag[3:0] ALU flags {V,C,N,Z}; only Z is used (BRANCH)
//   RW, ALU_op, C0, alu_m, MRW, WB, PCsrc, imm_sel, pc_we  datapath controls
//   retire           one-cycle pulse in the cycle an instruction completes
//   illegal          sticky unsupported-encoding flag
//   dbg_state        current FSM state for observation
module dp_control
    import dp_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inst_in,
    input  logic [3:0]  status_flag,
    output logic        RW,
    output logic [3:0]  ALU_op,
    output logic        C0,
    output logic        alu_m,
    output logic        MRW,
    output logic        WB,
    output logic        PCsrc,
    output logic [1:0]  imm_sel,
    output logic        pc_we,
    output logic        retire,
    output logic        illegal,
    output logic [2:0]  dbg_state
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;

    inst_class_e dec_cls;
    logic [3:0]  dec_alu_op;
    logic [1:0]  dec_imm_sel;
    logic        dec_legal;
    logic        unused_flags;

    assign unused_flags = ^status_flag[3:1];

    dp_decode u_decode (
        .inst    (ir_q),
        .cls     (dec_cls),
        .alu_op  (dec_alu_op),
        .imm_sel (dec_imm_sel),
        .legal   (dec_legal)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = inst_in;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (!dec_legal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else if (dec_cls == CLS_BR) begin
                    state_d = ST_BRANCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC:   state_d = (dec_cls == CLS_LW || dec_cls == CLS_SW) ? ST_MEM : ST_WBK;
            ST_MEM:    state_d = (dec_cls == CLS_LW) ? ST_WBK : ST_FETCH;
            ST_WBK:    state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Output decode. ALU controls stay valid from EXEC through MEM/WBK so the
    // address or result is stable while memory and the register file use it.
    always_comb begin
        RW      = 1'b0;
        ALU_op  = ALU_ADD;
        C0      = 1'b0;
        alu_m   = 1'b0;
        MRW     = 1'b1;
        WB      = 1'b0;
        PCsrc   = 1'b0;
        imm_sel = IMM_I;
        pc_we   = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_EXEC, ST_MEM, ST_WBK: begin
                ALU_op  = dec_alu_op;
                imm_sel = dec_imm_sel;
                alu_m   = (dec_cls == CLS_R);
                C0      = (state_q != ST_MEM) && (dec_alu_op == ALU_SUB);
                if (state_q == ST_MEM) begin
                    MRW = (dec_cls == CLS_LW);
                    if (dec_cls == CLS_SW) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                if (state_q == ST_WBK) begin
                    RW     = 1'b1;
                    WB     = (dec_cls == CLS_LW);
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            ST_BRANCH: begin
                alu_m   = 1'b1;
                ALU_op  = ALU_XOR;
                imm_sel = IMM_B;
                // funct3[0] distinguishes bne from beq.
                PCsrc   = ir_q[12] ? ~status_flag[FLAG_Z] : status_flag[FLAG_Z];
                pc_we   = 1'b1;
                retire  = 1'b1;
            end
            default: ;
        endcase
        // Reset suppresses every state-changing strobe immediately, so an
        // instruction aborted by reset never commits a partial write.
        if (reset) begin
            RW     = 1'b0;
            MRW    = 1'b1;
            pc_we  = 1'b0;
            retire = 1'b0;
        end
    end

    assign illegal   = illegal_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dp_control.sv
// Testbench for dp_control: directed and random instructions checked cycle by
// cycle against a per-instruction expected output schedule.
module tb_dp_control;

    localparam logic [3:0] A_ADD = 4'b0011;
    localparam logic [3:0] A_SUB = 4'b0101;
    localparam logic [3:0] A_AND = 4'b1000;
    localparam logic [3:0] A_OR  = 4'b1010;
    localparam logic [3:0] A_XOR = 4'b1100;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] inst_in;
    logic [3:0]  status_flag;
    logic        RW, C0, alu_m, MRW, WB, PCsrc, pc_we, retire, illegal;
    logic [3:0]  ALU_op;
    logic [1:0]  imm_sel;
    logic [2:0]  dbg_state;

    logic [14:0] obs;
    logic [14:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    dp_control dut (
        .clock       (clock),
        .reset       (reset),
        .inst_in     (inst_in),
        .status_flag (status_flag),
        .RW          (RW),
        .ALU_op      (ALU_op),
        .C0          (C0),
        .alu_m       (alu_m),
        .MRW         (MRW),
        .WB          (WB),
        .PCsrc       (PCsrc),
        .imm_sel     (imm_sel),
        .pc_we       (pc_we),
        .retire      (retire),
        .illegal     (illegal),
        .dbg_state   (dbg_state)
    );

    assign obs = {illegal, RW, ALU_op, C0, alu_m, MRW, WB, PCsrc, imm_sel, pc_we, retire};

    function automatic logic [14:0] mk(input logic ill, input logic rw, input logic [3:0] aop,
                                       input logic c0, input logic am, input logic mrw,
                                       input logic wb, input logic pcs, input logic [1:0] imm,
                                       input logic pwe, input logic ret);
        return {ill, rw, aop, c0, am, mrw, wb, pcs, imm, pwe, ret};
    endfunction

    task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Reference model: the whole output schedule of one instruction, one entry
    // per cycle starting with its FETCH cycle.
    task automatic build_expect(input logic [31:0] inst, input logic [3:0] fl);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [3:0]  aop;
        logic        ok;
        logic [14:0] idle;
        op   = inst[6:0];
        f3   = inst[14:12];
        f7   = inst[31:25];
        aop  = A_ADD;
        ok   = 1'b1;
        idle = mk(0, 0, A_ADD, 0, 0, 1, 0, 0, 2'b00, 0, 0);
        exp_q.push_back(idle);
        exp_q.push_back(idle);
        case (op)
            7'h33: begin
                case ({f7, f3})
                    10'h000: aop = A_ADD;
                    10'h100: aop = A_SUB;
                    10'h004: aop = A_XOR;
                    10'h006: aop = A_OR;
                    10'h007: aop = A_AND;
                    default: ok = 1'b0;
                endcase
                if (ok) begin
                    exp_q.push_back(mk(0, 0, aop, aop == A_SUB, 1, 1, 0, 0, 2'b00, 0, 0));
                    exp_q.push_back(mk(0, 1, aop, aop == A_SUB, 1, 1, 0, 0, 2'b00, 1, 1));
                end
            end
            7'h13: begin
                case (f3)
                    3'd0: aop = A_ADD;
                    3'd4: aop = A_XOR;
                    3'd6: aop = A_OR;
                    3'd7: aop = A_AND;
                    default: ok = 1'b0;
                endcase
                if (ok) begin
                    exp_q.push_back(mk(0, 0, aop, 0, 0, 1, 0, 0, 2'b00, 0, 0));
                    exp_q.push_back(mk(0, 1, aop, 0, 0, 1, 0, 0, 2'b00, 1, 1));
                end
            end
            7'h03: begin
                ok = (f3 == 3'd2);
                if (ok) begin
                    exp_q.push_back(mk(0, 0, A_ADD, 0, 0, 1, 0, 0, 2'b00, 0, 0));
                    exp_q.push_back(mk(0, 0, A_ADD, 0, 0, 1, 0, 0, 2'b00, 0, 0));
                    exp_q.push_back(mk(0, 1, A_ADD, 0, 0, 1, 1, 0, 2'b00, 1, 1));
                end
            end
            7'h23: begin
                ok = (f3 == 3'd2);
                if (ok) begin
                    exp_q.push_back(mk(0, 0, A_ADD, 0, 0, 1, 0, 0, 2'b01, 0, 0));
                    exp_q.push_back(mk(0, 0, A_ADD, 0, 0, 0, 0, 0, 2'b01, 1, 1));
                end
            end
            7'h63: begin
                ok = (f3 == 3'd0) || (f3 == 3'd1);
                if (ok)
                    exp_q.push_back(mk(0, 0, A_XOR, 0, 1, 1, 0,
                                       (f3 == 3'd0) ? fl[0] : !fl[0], 2'b10, 1, 1));
            end
            default: ok = 1'b0;
        endcase
        if (!ok)
            repeat (10) exp_q.push_back(mk(1, 0, A_ADD, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    endtask

    // Entered just after a clock edge with the DUT in FETCH.
    task automatic run_inst(input string tag, input logic [31:0] inst, input logic [3:0] fl);
        build_expect(inst, fl);
        inst_in     = inst;
        status_flag = fl;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            chk(tag, obs, exp_q.pop_front());
            @(posedge clock);
            #1;
            inst_in = $urandom;   // ir_q must hold the fetched word
        end
    endtask

    task automatic reset_pulse(input string tag);
        reset = 1'b1;
        @(negedge clock);
        chk(tag, {11'd0, RW, MRW, pc_we, retire}, {11'd0, 4'b0100});
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r, inst;
        logic [2:0]  f3;
        logic [2:0]  f3_tab[4];
        logic [6:0]  f7;
        f3_tab = '{3'd0, 3'd4, 3'd6, 3'd7};

        reset       = 1'b1;
        inst_in     = '0;
        status_flag = '0;
        @(posedge clock);
        @(negedge clock);
        chk("reset_gate", {11'd0, RW, MRW, pc_we, retire}, {11'd0, 4'b0100});
        @(posedge clock);
        #1;
        reset = 1'b0;

        run_inst("addi", 32'h00500093, 4'h0);
        run_inst("add",  32'h002081B3, 4'h0);
        run_inst("sub",  32'h402081B3, 4'h0);
        run_inst("lw",   32'h0040A283, 4'h0);
        run_inst("sw",   32'h0050A423, 4'h0);
        run_inst("beq_taken",    32'h00208463, 4'b0001);
        run_inst("beq_nottaken", 32'h00208463, 4'b0000);
        run_inst("bne_taken",    32'h00209463, 4'b1110);
        run_inst("bne_nottaken", 32'h00209463, 4'b0001);

        for (int n = 0; n < 60; n++) begin
            r  = $urandom;
            f3 = f3_tab[$urandom_range(0, 3)];
            case ($urandom_range(0, 4))
                0: begin
                    f7   = (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                    inst = {f7, r[24:15], f3, r[11:7], 7'h33};
                end
                1:       inst = {r[31:15], f3, r[11:7], 7'h13};
                2:       inst = {r[31:15], 3'd2, r[11:7], 7'h03};
                3:       inst = {r[31:15], 3'd2, r[11:7], 7'h23};
                default: inst = {r[31:15], 2'b00, r[12], r[11:7], 7'h63};
            endcase
            run_inst("random", inst, 4'($urandom_range(0, 15)));
        end

        run_inst("halt_ones", 32'hFFFFFFFF, 4'h0);
        reset_pulse("halt_reset_gate");
        run_inst("after_halt_addi", 32'h00500093, 4'h0);
        run_inst("halt_and_alt", 32'h4020F1B3, 4'h0);
        reset_pulse("halt_reset_gate2");
        run_inst("halt_lb", 32'h00008283, 4'h0);
        reset_pulse("halt_reset_gate3");

        // Reset arriving in WBK: compare FETCH/DECODE/EXEC, then abort.
        build_expect(32'h00500093, 4'h0);
        inst_in = 32'h00500093;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("wbk_abort_pre", obs, exp_q.pop_front());
            @(posedge clock);
            #1;
        end
        exp_q.delete();
        reset_pulse("wbk_abort_gate");
        run_inst("after_abort_lw", 32'h0040A283, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
